// File: rtl/filter_boundary_pad.sv
// filter_boundary_pad
//   Wraps the demosaiced RGB stream in a zero border of (kernelSize-1)/2 pixels on
//   every side so that the downstream 7x7 sharpening window never reads outside the
//   frame. A FIFO decouples the bursty input (idle gaps between rows) from the
//   contiguous padded output.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high
//   newFrame   single-cycle frame start pulse (restarts the frame from any state)
//   iValid     input pixel strobe
//   iR/iG/iB   demosaiced input pixel, 8 bits per channel
//   oR/oG/oB   padded output pixel, 0 in the border
//   oValid     output pixel strobe, one padded pixel per strobe in raster order
//   oDone      one-cycle pulse after the last padded pixel of a frame
//   oOverflow  sticky flag, set when an in-frame pixel is dropped on a full FIFO
module filter_boundary_pad #(
  parameter int unsigned width      = 320,
  parameter int unsigned height     = 240,
  parameter int unsigned kernelSize = 7,
  parameter int unsigned fifoDepth  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       newFrame,
  input  logic       iValid,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic       oValid,
  output logic       oDone,
  output logic       oOverflow
);

  localparam int unsigned BoundaryWidth = (kernelSize - 1) / 2;
  localparam int unsigned RowSize       = width + 2 * BoundaryWidth;
  localparam int unsigned PadRows       = height + 2 * BoundaryWidth;
  localparam int unsigned FramePixels   = width * height;
  localparam int unsigned ColW          = $clog2(RowSize);
  localparam int unsigned RowW          = $clog2(PadRows);
  localparam int unsigned PtrW          = $clog2(fifoDepth);
  localparam int unsigned CntW          = PtrW + 1;
  localparam int unsigned InW           = $clog2(FramePixels + 1);

  localparam logic [ColW-1:0] ColRowLast  = ColW'(RowSize - 1);
  localparam logic [ColW-1:0] ColBwLast   = ColW'(BoundaryWidth - 1);
  localparam logic [ColW-1:0] ColBodyLast = ColW'(width - 1);
  localparam logic [RowW-1:0] RowBwLast   = RowW'(BoundaryWidth - 1);
  localparam logic [RowW-1:0] RowBodyLast = RowW'(height - 1);
  localparam logic [CntW-1:0] CntFull     = CntW'(fifoDepth);
  localparam logic [InW-1:0]  InTotal     = InW'(FramePixels);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StTop    = 3'd1;
  localparam logic [2:0] StLeft   = 3'd2;
  localparam logic [2:0] StBody   = 3'd3;
  localparam logic [2:0] StRight  = 3'd4;
  localparam logic [2:0] StBottom = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  // State and counters
  logic [2:0]      r_state;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic [InW-1:0]  r_in_count;

  // FIFO
  logic [23:0]     r_mem [fifoDepth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  // Registered outputs
  logic [23:0] r_pix;
  logic        r_valid;
  logic        r_done;
  logic        r_overflow;

  logic            w_in_range;
  logic            w_wr_req;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_full;
  logic            w_empty;
  logic [PtrW-1:0] w_wr_addr;
  logic [23:0]     w_rd_data;

  logic [2:0]      w_state_d;
  logic [ColW-1:0] w_col_d;
  logic [RowW-1:0] w_row_d;
  logic [23:0]     w_pix_d;
  logic            w_valid_d;
  logic            w_done_d;

  // A newFrame pixel is always the first pixel of the new frame, so it bypasses the
  // range check and lands in the freshly flushed FIFO.
  assign w_full     = (r_count == CntFull);
  assign w_empty    = (r_count == '0);
  assign w_in_range = newFrame | (r_in_count < InTotal);
  assign w_wr_req   = iValid & w_in_range;
  assign w_wr_en    = w_wr_req & (newFrame | ~w_full);
  assign w_rd_en    = (r_state == StBody) & ~w_empty & ~newFrame;
  assign w_wr_addr  = newFrame ? '0 : r_wr_ptr;
  assign w_rd_data  = r_mem[r_rd_ptr];

  always_comb begin
    w_state_d = r_state;
    w_col_d   = r_col;
    w_row_d   = r_row;
    w_pix_d   = '0;
    w_valid_d = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      StTop, StBottom: begin
        w_valid_d = 1'b1;
        if (r_col == ColRowLast) begin
          w_col_d = '0;
          if (r_row == RowBwLast) begin
            w_row_d   = '0;
            w_state_d = (r_state == StTop) ? StLeft : StDone;
          end else begin
            w_row_d = r_row + 1'b1;
          end
        end else begin
          w_col_d = r_col + 1'b1;
        end
      end
      StLeft: begin
        w_valid_d = 1'b1;
        if (r_col == ColBwLast) begin
          w_col_d   = '0;
          w_state_d = StBody;
        end else begin
          w_col_d = r_col + 1'b1;
        end
      end
      StBody: begin
        // Empty FIFO stalls the row: no strobe, column holds.
        if (!w_empty) begin
          w_valid_d = 1'b1;
          w_pix_d   = w_rd_data;
          if (r_col == ColBodyLast) begin
            w_col_d   = '0;
            w_state_d = StRight;
          end else begin
            w_col_d = r_col + 1'b1;
          end
        end
      end
      StRight: begin
        w_valid_d = 1'b1;
        if (r_col == ColBwLast) begin
          w_col_d = '0;
          if (r_row == RowBodyLast) begin
            w_row_d   = '0;
            w_state_d = StBottom;
          end else begin
            w_row_d   = r_row + 1'b1;
            w_state_d = StLeft;
          end
        end else begin
          w_col_d = r_col + 1'b1;
        end
      end
      StDone: begin
        w_done_d  = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Restart wins over everything; an aborted frame never reaches StDone.
    if (newFrame) begin
      w_state_d = StTop;
      w_col_d   = '0;
      w_row_d   = '0;
      w_pix_d   = '0;
      w_valid_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // Storage has no reset so it can map onto a RAM; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= {iR, iG, iB};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_col      <= '0;
      r_row      <= '0;
      r_in_count <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pix      <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_col   <= w_col_d;
      r_row   <= w_row_d;
      r_pix   <= w_pix_d;
      r_valid <= w_valid_d;
      r_done  <= w_done_d;
      if (w_wr_req && w_full && !newFrame) begin
        r_overflow <= 1'b1;
      end
      if (newFrame) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= PtrW'(w_wr_en);
        r_count    <= CntW'(w_wr_en);
        r_in_count <= InW'(iValid);
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_rd_en) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_wr_en && !w_rd_en) begin
          r_count <= r_count + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
          r_count <= r_count - 1'b1;
        end
        // Dropped pixels still count toward the frame so later pixels keep position.
        if (w_wr_req) begin
          r_in_count <= r_in_count + 1'b1;
        end
      end
    end
  end

  assign oR        = r_pix[23:16];
  assign oG        = r_pix[15:8];
  assign oB        = r_pix[7:0];
  assign oValid    = r_valid;
  assign oDone     = r_done;
  assign oOverflow = r_overflow;

endmodule

// File: tb/tb_filter_boundary_pad.sv
// Directed bench for filter_boundary_pad: small 8x4 frame (kernel 7) plus a
// 32-wide, 16-deep instance for the overflow flag.
module tb_filter_boundary_pad;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int BW   = 3;
  localparam int RS   = W + 2 * BW;
  localparam int NOUT = RS * (H + 2 * BW);

  logic       clk = 1'b0;
  logic       reset, newFrame, iValid;
  logic [7:0] iR, iG, iB, oR, oG, oB;
  logic       oValid, oDone, oOverflow;

  logic       ov_reset, ov_newFrame, ov_iValid;
  logic [7:0] ov_iR, ov_iG, ov_iB, ov_oR, ov_oG, ov_oB;
  logic       ov_oValid, ov_oDone, ov_oOverflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_boundary_pad #(
    .width(8), .height(4), .kernelSize(7), .fifoDepth(1024)
  ) u_dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid),
    .iR(iR), .iG(iG), .iB(iB), .oR(oR), .oG(oG), .oB(oB),
    .oValid(oValid), .oDone(oDone), .oOverflow(oOverflow)
  );

  filter_boundary_pad #(
    .width(32), .height(2), .kernelSize(7), .fifoDepth(16)
  ) u_ovf (
    .clk(clk), .reset(ov_reset), .newFrame(ov_newFrame), .iValid(ov_iValid),
    .iR(ov_iR), .iG(ov_iG), .iB(ov_iB), .oR(ov_oR), .oG(ov_oG), .oB(ov_oB),
    .oValid(ov_oValid), .oDone(ov_oDone), .oOverflow(ov_oOverflow)
  );

  // Capture every strobed output pixel and every done pulse of the main instance.
  logic [23:0] cap [0:2047];
  int out_count  = 0;
  int done_count = 0;

  always @(posedge clk) begin
    #1;
    if (oValid && out_count < 2048) begin
      cap[out_count] <= {oR, oG, oB};
      out_count      <= out_count + 1;
    end
    if (oDone) done_count <= done_count + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int j);
    int r;
    int c;
    int p;
    r = j / RS;
    c = j % RS;
    if (r >= BW && r < BW + H && c >= BW && c < BW + W) begin
      p = (r - BW) * W + (c - BW);
      return {8'(p), 8'(p), 8'(p + 1)};
    end
    return 24'h0;
  endfunction

  task automatic check_frame(input int base);
    for (int j = 0; j < NOUT; j++) begin
      check($sformatf("pix%0d", j), 32'(cap[base + j]), 32'(exp_pix(j)));
    end
  endtask

  // Pixel i = (i, i, i+1); 16 idle cycles after each row.
  task automatic feed(input int first);
    for (int i = first; i < W * H; i++) begin
      iValid = 1'b1;
      iR = 8'(i);
      iG = 8'(i);
      iB = 8'(i + 1);
      tick();
      if (i % W == W - 1) begin
        iValid = 1'b0;
        repeat (16) tick();
      end
    end
    iValid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n;
    n = 0;
    while (done_count < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(done_count), 32'(target));
  endtask

  task automatic wait_count(input int base, input int target, input string tag);
    int n;
    n = 0;
    while (out_count - base < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 32'(out_count - base), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_oR"}, 32'(oR), 32'h0);
    check({tag, "_oG"}, 32'(oG), 32'h0);
    check({tag, "_oB"}, 32'(oB), 32'h0);
    check({tag, "_oValid"}, 32'(oValid), 32'h0);
    check({tag, "_oDone"}, 32'(oDone), 32'h0);
    check({tag, "_oOverflow"}, 32'(oOverflow), 32'h0);
  endtask

  int base;

  initial begin
    reset = 1'b1; newFrame = 1'b0; iValid = 1'b0; iR = '0; iG = '0; iB = '0;
    ov_reset = 1'b1; ov_newFrame = 1'b0; ov_iValid = 1'b0;
    ov_iR = '0; ov_iG = '0; ov_iB = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    ov_reset = 1'b0;
    tick();

    // Frame A: full frame, then junk valids that must be ignored.
    base = out_count;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    feed(0);
    iValid = 1'b1; iR = 8'hAA; iG = 8'h55; iB = 8'hAA;
    wait_done(1, "A_done");
    repeat (50) tick();
    iValid = 1'b0;
    check("A_count", 32'(out_count - base), 32'(NOUT));
    check("A_done_once", 32'(done_count), 32'd1);
    check("A_idle_valid", 32'(oValid), 32'h0);
    check("A_overflow", 32'(oOverflow), 32'h0);
    check_frame(base);

    // Frame B: border prefix, 2-cycle latency into an empty FIFO, then stall mid row 2.
    base = out_count;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    wait_count(base, 2 * RS * BW / 2 + BW, "B_lead");
    iValid = 1'b1; iR = 8'd0; iG = 8'd0; iB = 8'd1;
    tick();
    iValid = 1'b0;
    check("B_lat_edge1", 32'(oValid), 32'h0);
    tick();
    check("B_lat_edge2", 32'(oValid), 32'h1);
    check("B_lat_data", 32'({oR, oG, oB}), 32'h000001);
    for (int i = 1; i < 20; i++) begin
      iValid = 1'b1; iR = 8'(i); iG = 8'(i); iB = 8'(i + 1);
      tick();
    end
    iValid = 1'b0;
    repeat (80) tick();
    check("B_stall_count", 32'(out_count - base), 32'd77);
    check("B_stall_valid", 32'(oValid), 32'h0);

    // Frame C: newFrame aborts B mid-body with the first new pixel in the same cycle.
    base = out_count;
    newFrame = 1'b1;
    iValid = 1'b1; iR = 8'd0; iG = 8'd0; iB = 8'd1;
    tick();
    newFrame = 1'b0;
    feed(1);
    wait_done(2, "C_done");
    repeat (20) tick();
    check("C_count", 32'(out_count - base), 32'(NOUT));
    check("C_done_once", 32'(done_count), 32'd2);
    check_frame(base);

    // Frame D: reset while emitting the bottom border.
    base = out_count;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    feed(0);
    wait_count(base, 120, "D_in_bottom");
    reset = 1'b1;
    tick();
    check_idle_outputs("D_reset");
    reset = 1'b0;
    repeat (200) tick();
    check("D_no_more_valid", 32'(out_count - base), 32'd120);
    check("D_no_done", 32'(done_count), 32'd2);

    // Frame E: clean frame after the reset.
    base = out_count;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
    feed(0);
    wait_done(3, "E_done");
    check("E_count", 32'(out_count - base), 32'(NOUT));
    check_frame(base);

    // Overflow: 16-deep FIFO fills during the 114-cycle top border.
    ov_newFrame = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ov_iValid = 1'b1; ov_iR = 8'(i); ov_iG = 8'(i); ov_iB = 8'(i);
      tick();
      ov_newFrame = 1'b0;
      if (i == 15) check("ovf_at_full", 32'(ov_oOverflow), 32'h0);
      if (i == 16) check("ovf_first_drop", 32'(ov_oOverflow), 32'h1);
    end
    ov_iValid = 1'b0;
    repeat (30) tick();
    check("ovf_sticky", 32'(ov_oOverflow), 32'h1);
    ov_newFrame = 1'b1;
    tick();
    ov_newFrame = 1'b0;
    tick();
    check("ovf_survives_newframe", 32'(ov_oOverflow), 32'h1);
    ov_reset = 1'b1;
    tick();
    check("ovf_cleared_by_reset", 32'(ov_oOverflow), 32'h0);
    ov_reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
